// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester byte streams, transmitter pins and grant status of the shared UART transmitter.
interface uart_tx_arbiter_if #(
    parameter int NREQ = 4
) ();
    localparam int GW = $clog2(NREQ);
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_busy;
    logic              grant_valid;
    logic [GW-1:0]     grant_id;
    logic              timeout_pulse;
    modport master (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, tx_start, tx_data, grant_valid, grant_id, timeout_pulse
    );
    modport slave (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, tx_start, tx_data, grant_valid, grant_id, timeout_pulse
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-granular round-robin sharing of one async_transmitter, with stall timeout.
module uart_tx_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 50000
) (
    input logic clk,
    input logic rst,
    uart_tx_arbiter_if.slave bus
);
    localparam int GW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO} state_t;

    state_t          state_q, state_d;
    logic            grant_valid_q, grant_valid_d;
    logic [GW-1:0]   grant_id_q, grant_id_d;
    logic [GW-1:0]   rr_q, rr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            tx_start_q, tx_start_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            last_q, last_d;
    logic            timeout_q, timeout_d;
    logic [GW-1:0]   pick;
    logic [NREQ-1:0] rdy;
    logic            gv, glast, xfer, expire;
    logic [7:0]      gdata;

    function automatic logic [GW-1:0] wrap_inc(input logic [GW-1:0] a, input int k);
        return GW'((int'(a) + k) % NREQ);
    endfunction

    always_comb begin
        pick  = rr_q;
        gv    = 1'b0;
        glast = 1'b0;
        gdata = '0;
        rdy   = '0;
        // descending scan so the requester closest to the rr pointer wins
        for (int k = NREQ - 1; k >= 0; k--)
            pick = bus.req_valid[wrap_inc(rr_q, k)] ? wrap_inc(rr_q, k) : pick;
        for (int i = 0; i < NREQ; i++) begin
            rdy[i] = state_q == ISSUE && !bus.tx_busy && grant_id_q == GW'(i);
            gv     = grant_id_q == GW'(i) ? bus.req_valid[i] : gv;
            glast  = grant_id_q == GW'(i) ? bus.req_last[i] : glast;
            gdata  = grant_id_q == GW'(i) ? bus.req_data[8*i +: 8] : gdata;
        end
        xfer          = state_q == ISSUE && !bus.tx_busy && gv;
        expire        = state_q == ISSUE && !gv && cnt_q == CW'(TIMEOUT - 1);
        tx_start_d    = xfer;
        tx_data_d     = xfer ? gdata : tx_data_q;
        last_d        = xfer ? glast : last_q;
        cnt_d         = (state_q != ISSUE || gv) ? '0 : (cnt_q == CW'(TIMEOUT)) ? cnt_q : cnt_q + 1'b1;
        timeout_d     = expire;
        state_d       = state_q;
        grant_valid_d = grant_valid_q;
        grant_id_d    = grant_id_q;
        rr_d          = rr_q;
        case (state_q)
            IDLE: begin
                state_d       = |bus.req_valid ? ISSUE : IDLE;
                grant_valid_d = |bus.req_valid;
                grant_id_d    = |bus.req_valid ? pick : grant_id_q;
            end
            ISSUE: begin
                state_d       = xfer ? WAIT_HI : expire ? IDLE : ISSUE;
                grant_valid_d = !expire;
                rr_d          = expire ? wrap_inc(grant_id_q, 1) : rr_q;
            end
            // busy is still low right after the start pulse; wait for it to rise first
            WAIT_HI: state_d = bus.tx_busy ? WAIT_LO : WAIT_HI;
            WAIT_LO: begin
                state_d       = bus.tx_busy ? WAIT_LO : last_q ? IDLE : ISSUE;
                grant_valid_d = bus.tx_busy || !last_q;
                rr_d          = (!bus.tx_busy && last_q) ? wrap_inc(grant_id_q, 1) : rr_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
            rr_q          <= '0;
            cnt_q         <= '0;
            tx_start_q    <= 1'b0;
            tx_data_q     <= '0;
            last_q        <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_valid_q <= grant_valid_d;
            grant_id_q    <= grant_id_d;
            rr_q          <= rr_d;
            cnt_q         <= cnt_d;
            tx_start_q    <= tx_start_d;
            tx_data_q     <= tx_data_d;
            last_q        <= last_d;
            timeout_q     <= timeout_d;
        end
    end

    assign bus.req_ready     = rdy;
    assign bus.tx_start      = tx_start_q;
    assign bus.tx_data       = tx_data_q;
    assign bus.grant_valid   = grant_valid_q;
    assign bus.grant_id      = grant_id_q;
    assign bus.timeout_pulse = timeout_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized requesters and transmitter model against a packet-level round-robin reference.
module tb_uart_tx_arbiter;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NREQ(NREQ)) ifc ();
    uart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (.clk(clk), .rst(rst), .bus(ifc));

    int n_chk = 0, n_err = 0, n_start = 0, to_cnt = 0, model_rr = 0;
    int bl_lo = 1, bl_hi = 4, bcnt = 0;
    logic force_busy = 1'b1, busy_seen = 1'b1, dref_v = 1'b0, to_prev = 1'b0;
    logic [7:0] dref = '0;
    logic [NREQ-1:0] fire;
    logic [8:0] rq [NREQ][$];
    logic [8:0] mq [NREQ][$];
    logic [7:0] exp_q [$];
    int exp_id [$];

    // transmitter: goes busy the cycle after the start pulse, for a random number of cycles
    assign ifc.tx_busy = force_busy || bcnt != 0;
    always @(posedge clk) bcnt <= ifc.tx_start ? int'($urandom_range(bl_hi, bl_lo)) : (bcnt > 0 ? bcnt - 1 : 0);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_update();
        logic [NREQ-1:0] v, l;
        logic [8*NREQ-1:0] d;
        v = '0; l = '0; d = '0;
        for (int i = 0; i < NREQ; i++)
            if (rq[i].size() > 0) begin
                v[i] = 1'b1;
                l[i] = rq[i][0][8];
                d[8*i +: 8] = rq[i][0][7:0];
            end
        ifc.req_valid = v;
        ifc.req_last  = l;
        ifc.req_data  = d;
    endtask

    task automatic add_byte(input int i, input logic [7:0] b, input logic last);
        rq[i].push_back({last, b});
        mq[i].push_back({last, b});
    endtask

    // reference: whole packets, next requester at or after the pointer, pointer moves past the winner
    task automatic plan();
        logic [8:0] w;
        while (1) begin
            int i;
            i = -1;
            for (int k = 0; k < NREQ; k++)
                if (i < 0 && mq[(model_rr + k) % NREQ].size() > 0) i = (model_rr + k) % NREQ;
            if (i < 0) break;
            do begin
                w = mq[i].pop_front();
                exp_q.push_back(w[7:0]);
                exp_id.push_back(i);
            end while (!w[8] && mq[i].size() > 0);
            model_rr = (i + 1) % NREQ;
        end
    endtask

    task automatic wait_drain();
        bit done;
        done = 0;
        for (int t = 0; t < 800 && !done; t++) begin
            @(negedge clk);
            done = exp_q.size() == 0 && !ifc.grant_valid && !ifc.tx_busy && ifc.req_valid == '0;
        end
        check("drain", 32'(done), 1);
    endtask

    task automatic wait_start();
        int s;
        s = n_start;
        for (int t = 0; t < 300 && n_start == s; t++) @(negedge clk);
        check("start_seen", 32'(n_start != s), 1);
    endtask

    initial begin : driver
        forever begin
            @(negedge clk);
            #4 fire = ifc.req_valid & ifc.req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++)
                if (fire[i] && rq[i].size() > 0) rq[i].delete(0);
            drive_update();
        end
    end

    always @(negedge clk) begin : monitor
        logic [7:0] eb;
        int ei;
        if (!rst) begin
            if (ifc.tx_start) begin
                n_start++;
                check("start_idle", 32'(ifc.tx_busy), 0);
                check("start_gap", 32'(busy_seen), 1);
                busy_seen = 1'b0;
                if (exp_q.size() == 0) check("exp_avail", exp_q.size(), 1);
                else begin
                    eb = exp_q.pop_front();
                    ei = exp_id.pop_front();
                    check("tx_byte", 32'(ifc.tx_data), 32'(eb));
                    check("tx_owner", 32'(ifc.grant_id), ei);
                end
                dref   = ifc.tx_data;
                dref_v = 1'b1;
            end
            if (ifc.tx_busy) busy_seen = 1'b1;
            if (ifc.tx_busy && dref_v) check("data_stable", 32'(ifc.tx_data), 32'(dref));
            if (ifc.timeout_pulse) begin
                to_cnt++;
                check("to_grant", 32'(ifc.grant_valid), 0);
                check("to_width", 32'(to_prev), 0);
            end
            to_prev = ifc.timeout_pulse;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, s, t0;
        bit hit;
        drive_update();
        add_byte(0, 8'h55, 1'b1);
        plan();
        drive_update();
        repeat (2) @(negedge clk);
        check("rst_gv", 32'(ifc.grant_valid), 0);
        check("rst_gid", 32'(ifc.grant_id), 0);
        check("rst_rdy", 32'(ifc.req_ready), 0);
        check("rst_start", 32'(ifc.tx_start), 0);
        check("rst_data", 32'(ifc.tx_data), 0);
        check("rst_to", 32'(ifc.timeout_pulse), 0);
        #1 rst = 1'b0;
        @(negedge clk);
        check("t1_gv", 32'(ifc.grant_valid), 1);
        check("t1_gid", 32'(ifc.grant_id), 0);
        repeat (18) begin
            @(negedge clk);
            check("t1_rdy_busy", 32'(ifc.req_ready), 0);
        end
        #1 force_busy = 1'b0;
        #1 check("t1_rdy", 32'(ifc.req_ready), 1);
        wait_drain();
        check("t1_starts", n_start, 1);

        @(negedge clk);
        #1 rst = 1'b1;
        model_rr = 0;
        @(negedge clk);
        #1 rst = 1'b0;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NREQ; i++) add_byte(i, 8'h10 + 8'(i), 1'b1);
        plan();
        drive_update();
        wait_drain();
        check("rr_starts", n_start, 9);

        add_byte(0, 8'h01, 1'b0);
        add_byte(0, 8'h02, 1'b0);
        add_byte(0, 8'h03, 1'b1);
        add_byte(1, 8'hA0, 1'b1);
        plan();
        drive_update();
        wait_drain();
        check("pkt_starts", n_start, 13);

        rq[2].push_back({1'b0, 8'h77});
        exp_q.push_back(8'h77);
        exp_id.push_back(2);
        drive_update();
        wait_start();
        n = 0;
        hit = 0;
        for (int t = 0; t < 100 && !hit; t++) begin
            @(negedge clk);
            if (ifc.timeout_pulse) hit = 1;
            else if (ifc.req_ready[2]) n++;
        end
        check("to_fired", 32'(hit), 1);
        check("to_cycles", n, TIMEOUT);
        model_rr = (2 + 1) % NREQ;
        @(negedge clk);
        check("to_clear", 32'(ifc.timeout_pulse), 0);
        add_byte(0, 8'hC0, 1'b1);
        add_byte(2, 8'hC2, 1'b1);
        plan();
        drive_update();
        wait_drain();

        t0 = to_cnt;
        rq[1].push_back({1'b0, 8'h33});
        exp_q.push_back(8'h33);
        exp_id.push_back(1);
        drive_update();
        wait_start();
        n = 0;
        for (int t = 0; t < 100 && n < TIMEOUT - 1; t++) begin
            @(negedge clk);
            if (ifc.req_ready[1]) n++;
        end
        check("late_reach", n, TIMEOUT - 1);
        @(posedge clk);
        #2 rq[1].push_back({1'b1, 8'h34});
        exp_q.push_back(8'h34);
        exp_id.push_back(1);
        drive_update();
        wait_drain();
        check("late_no_to", to_cnt, t0);
        model_rr = (1 + 1) % NREQ;

        bl_lo = 10;
        bl_hi = 10;
        rq[1].push_back({1'b0, 8'hA1});
        rq[1].push_back({1'b0, 8'hA2});
        rq[1].push_back({1'b1, 8'hA3});
        exp_q.push_back(8'hA1);
        exp_id.push_back(1);
        drive_update();
        wait_start();
        for (int t = 0; t < 50 && !ifc.tx_busy; t++) @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        dref_v = 1'b0;
        #1;
        check("arst_gv", 32'(ifc.grant_valid), 0);
        check("arst_gid", 32'(ifc.grant_id), 0);
        check("arst_start", 32'(ifc.tx_start), 0);
        check("arst_data", 32'(ifc.tx_data), 0);
        check("arst_rdy", 32'(ifc.req_ready), 0);
        check("arst_to", 32'(ifc.timeout_pulse), 0);
        rq[1].delete();
        exp_q.delete();
        exp_id.delete();
        model_rr = 0;
        drive_update();
        @(negedge clk);
        #1 rst = 1'b0;
        check("arst_busy_held", 32'(ifc.tx_busy), 1);
        for (int i = 0; i < NREQ; i++) add_byte(i, 8'h20 + 8'(i), 1'b1);
        plan();
        drive_update();
        bl_lo = 1;
        bl_hi = 5;
        wait_drain();

        for (int r = 0; r < 20; r++) begin
            s = n_start;
            n = 0;
            for (int i = 0; i < NREQ; i++)
                for (int p = $urandom_range(0, 2); p > 0; p--) begin
                    int len;
                    len = $urandom_range(1, 3);
                    for (int b = 0; b < len; b++) add_byte(i, 8'($urandom), b == len - 1);
                    n += len;
                end
            plan();
            drive_update();
            wait_drain();
            check("rand_starts", n_start - s, n);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
